icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Control unit for the two-way, eight-set, pipelined instruction cache datapath. It sequences the two-stage lookup (array read, then tag compare), steers fills from physical memory into the victim way, maintains LRU and valid state, and stalls the front end on a miss. It sits between the fetch stage, the icache datapath and the physical-memory port, and it exports hit and miss counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 32, width of the hit and miss counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  fetch request valid at stage 1.
- pipe_mem_read  in  1  stage-2 request valid, i.e. the mem_read field of the stage-2 control word.
- hit  in  1  stage-2 hit (tag0_hit | tag1_hit).
- tag0_hit, tag1_hit  in  1 each  per-way stage-2 hit.
- lru_out  in  1  LRU bit for the current index; 1 means way 1 is LRU.
- pmem_resp  in  1  physical memory done; pmem_rdata is valid only in this cycle.
- read_data  out  1  array read enable for the tag and data arrays.
- load_pipeline  out  1  advance the stage-1 to stage-2 registers.
- load_lru  out  1  write the LRU array; the datapath writes the value tag0_hit.
- load_data  out  2  per-way data array write enable.
- load_tag  out  2  per-way tag array write enable.
- set_valid0, set_valid1  out  1 each  per-way valid set.
- pmem_read  out  1  line read request to physical memory.
- mem_resp  out  1  fetch data valid on mem_rdata256 this cycle.
- hit_count, miss_count  out  CNT_W each  saturating performance counters.

## Operation
- The FSM has three states: RUN, MISS and REFETCH. Reset enters RUN.
- A registered flag, s2_stale, marks a stage-2 entry that has already been served. Reset clears it. It is set on leaving MISS and cleared on any cycle where load_pipeline=1.
- s2_live = pipe_mem_read & ~s2_stale.
- RUN:
  - read_data=1.
  - If s2_live & hit: mem_resp=1, load_lru=1, load_pipeline=1, and hit_count increments.
  - If s2_live & ~hit: load_pipeline=0 and the next state is MISS. miss_count increments on this transition only.
  - Otherwise (bubble or stale entry): load_pipeline=1 and no response.
- MISS:
  - pmem_read=1, read_data=0, load_pipeline=0.
  - The victim is way1 if lru_out=1, else way0.
  - In the pmem_resp cycle, load_data[victim]=1, load_tag[victim]=1 and set_valid[victim]=1. mem_resp=1, because the datapath forwards pmem_rdata when hit=0. The next state is REFETCH.
  - In the same cycle, load_lru=1 only when the victim is way1. This writes LRU=0, making way0 LRU. When the victim is way0, LRU is left unchanged (the datapath cannot write 1 on a miss). This is a known approximation.
- REFETCH:
  - read_data=1, load_pipeline=0, for exactly one cycle, then RUN.
  - This re-reads the arrays for the held stage-1 address, so that a same-set follow-on request sees the new line.
- Counters saturate at all-ones and never wrap.
- Only one way's write enables are ever asserted at a time. load_data, load_tag and set_valid* are zero outside the MISS pmem_resp cycle.

## Timing
- Reset values: every output is 0, the state is RUN, s2_stale=0 and both counters are 0.
- Asserting rst_n low during MISS drops pmem_read immediately (combinational from state), with no array write.
- Hit: mem_resp is asserted in the same cycle s2_live and hit are seen. Throughput is one fetch per cycle.
- Miss detected in cycle N:
  - MISS runs from N+1. pmem_read is high from N+1 through the pmem_resp cycle M inclusive.
  - mem_resp and the fill happen in cycle M.
  - REFETCH is cycle M+1.
  - RUN resumes at M+2. Stage 2 is stale in that cycle, so load_pipeline=1 with no response.
  - The next request is resolvable in M+3.
- pmem_resp in the same cycle pmem_read first rises (M=N+1) is legal. pmem_resp outside MISS is ignored.
- mem_read low does not stall. Bubbles flow through with pipe_mem_read=0.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. All outputs are 0, and the first RUN cycle has read_data=1 and load_pipeline=1.
- Cold miss on a 0x0000_0040 fetch with lru_out=0 and pmem_resp 5 cycles later:
  - pmem_read is high for exactly 5 cycles.
  - In the resp cycle, load_data=2'b01, load_tag=2'b01, set_valid0=1, mem_resp=1 and load_lru=0.
  - REFETCH follows, and miss_count=1.
- Victim way1 (lru_out=1) miss: load_data=2'b10, set_valid1=1 and load_lru=1 in the resp cycle.
- Back-to-back hits on 0x40, 0x44, 0x48 after the fill: mem_resp=1 on three consecutive cycles, load_lru=1 each cycle, and hit_count=3.
- Same-set follow-on: a miss to 0x0000_0100, then 0x0000_0100 again immediately. The second access hits after REFETCH with exactly one response, and the stale stage-2 entry produces no duplicate mem_resp.
- Counter saturation: preload hit_count to all-ones via force, then one hit. The count stays all-ones.

Source files
------------

// File: rtl/icache_ctrl.sv
// Control FSM for the two-way, eight-set pipelined instruction cache.
// It sequences lookup, miss fill and refetch, and keeps saturating hit/miss counters.
module icache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             pipe_mem_read,
    input  logic             hit,
    input  logic             tag0_hit,
    input  logic             tag1_hit,
    input  logic             lru_out,
    input  logic             pmem_resp,
    output logic             read_data,
    output logic             load_pipeline,
    output logic             load_lru,
    output logic [1:0]       load_data,
    output logic [1:0]       load_tag,
    output logic             set_valid0,
    output logic             set_valid1,
    output logic             pmem_read,
    output logic             mem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MISS    = 2'd1,
        REFETCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             s2_stale_r;
    logic [CNT_W-1:0] hit_count_r;
    logic [CNT_W-1:0] miss_count_r;

    logic       s2_live_s;
    logic       run_hit_s;
    logic       run_miss_s;
    logic       fill_s;
    logic       read_data_s;
    logic       load_pipeline_s;
    logic       load_lru_s;
    logic       mem_resp_s;
    logic       pmem_read_s;
    logic [1:0] load_data_s;
    logic [1:0] load_tag_s;
    logic       set_valid0_s;
    logic       set_valid1_s;
    logic       unused_inputs_s;

    // The per-way hits and the stage-1 valid carry no extra information for sequencing.
    assign unused_inputs_s = ^{mem_read, tag0_hit, tag1_hit};

    assign s2_live_s  = pipe_mem_read & ~s2_stale_r;
    assign run_hit_s  = (state_r == RUN) & s2_live_s & hit;
    assign run_miss_s = (state_r == RUN) & s2_live_s & ~hit;
    assign fill_s     = (state_r == MISS) & pmem_resp;

    // Per-state control decode; fill enables steer to the LRU victim way.
    always_comb begin
        read_data_s     = 1'b0;
        load_pipeline_s = 1'b0;
        load_lru_s      = 1'b0;
        mem_resp_s      = 1'b0;
        pmem_read_s     = 1'b0;
        load_data_s     = 2'b00;
        load_tag_s      = 2'b00;
        set_valid0_s    = 1'b0;
        set_valid1_s    = 1'b0;
        case (state_r)
            RUN: begin
                read_data_s = 1'b1;
                if (run_hit_s) begin
                    mem_resp_s      = 1'b1;
                    load_lru_s      = 1'b1;
                    load_pipeline_s = 1'b1;
                end else if (run_miss_s) begin
                    load_pipeline_s = 1'b0;
                end else begin
                    load_pipeline_s = 1'b1;
                end
            end
            MISS: begin
                pmem_read_s = 1'b1;
                if (pmem_resp) begin
                    mem_resp_s   = 1'b1;
                    // Only way1 victims can move LRU: the datapath writes tag0_hit (0 here).
                    load_lru_s   = lru_out;
                    load_data_s  = lru_out ? 2'b10 : 2'b01;
                    load_tag_s   = lru_out ? 2'b10 : 2'b01;
                    set_valid0_s = ~lru_out;
                    set_valid1_s = lru_out;
                end else begin
                    mem_resp_s = 1'b0;
                end
            end
            REFETCH: begin
                read_data_s = 1'b1;
            end
            default: begin
                read_data_s = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign read_data     = read_data_s & rst_n;
    assign load_pipeline = load_pipeline_s & rst_n;
    assign load_lru      = load_lru_s & rst_n;
    assign mem_resp      = mem_resp_s & rst_n;
    assign pmem_read     = pmem_read_s & rst_n;
    assign load_data     = load_data_s & {2{rst_n}};
    assign load_tag      = load_tag_s & {2{rst_n}};
    assign set_valid0    = set_valid0_s & rst_n;
    assign set_valid1    = set_valid1_s & rst_n;
    assign hit_count     = hit_count_r;
    assign miss_count    = miss_count_r;

    // State transitions and the stage-2 stale marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            s2_stale_r <= 1'b0;
        end else begin
            if (fill_s) begin
                s2_stale_r <= 1'b1;
            end else if (load_pipeline_s) begin
                s2_stale_r <= 1'b0;
            end
            case (state_r)
                RUN:     state_r <= run_miss_s ? MISS : RUN;
                MISS:    state_r <= pmem_resp ? REFETCH : MISS;
                REFETCH: state_r <= RUN;
                default: state_r <= RUN;
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= {CNT_W{1'b0}};
            miss_count_r <= {CNT_W{1'b0}};
        end else begin
            if (run_hit_s && (hit_count_r != CNT_MAX)) begin
                hit_count_r <= hit_count_r + CNT_ONE;
            end
            if (run_miss_s && (miss_count_r != CNT_MAX)) begin
                miss_count_r <= miss_count_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a cycle-by-cycle vector table plus
// hand-written miss, hit-burst, follow-on, saturation and reset sequences.
module tb_icache_ctrl;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_read, pipe_mem_read, hit, tag0_hit, tag1_hit, lru_out, pmem_resp;
    logic             read_data, load_pipeline, load_lru, set_valid0, set_valid1;
    logic             pmem_read, mem_resp;
    logic [1:0]       load_data, load_tag;
    logic [CNT_W-1:0] hit_count, miss_count;

    icache_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .pipe_mem_read(pipe_mem_read),
        .hit(hit), .tag0_hit(tag0_hit), .tag1_hit(tag1_hit), .lru_out(lru_out),
        .pmem_resp(pmem_resp), .read_data(read_data), .load_pipeline(load_pipeline),
        .load_lru(load_lru), .load_data(load_data), .load_tag(load_tag),
        .set_valid0(set_valid0), .set_valid1(set_valid1), .pmem_read(pmem_read),
        .mem_resp(mem_resp), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Output word: {read_data, load_pipeline, load_lru, mem_resp, pmem_read, load_data, load_tag, set_valid0, set_valid1}
    localparam logic [10:0] E_ZERO  = 11'b00000_00_00_00;
    localparam logic [10:0] E_BUB   = 11'b11000_00_00_00;
    localparam logic [10:0] E_MDET  = 11'b10000_00_00_00;
    localparam logic [10:0] E_MWAIT = 11'b00001_00_00_00;
    localparam logic [10:0] E_FILL1 = 11'b00111_10_10_01;
    localparam logic [10:0] E_FILL0 = 11'b00011_01_01_10;
    localparam logic [10:0] E_REF   = 11'b10000_00_00_00;
    localparam logic [10:0] E_HIT   = 11'b11110_00_00_00;

    typedef struct {
        logic        pmr, h, t0, t1, lru, resp;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [13];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;
    int   cnt;

    function automatic logic [31:0] outs();
        return {21'd0, read_data, load_pipeline, load_lru, mem_resp, pmem_read,
                load_data, load_tag, set_valid0, set_valid1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic pmr, input logic h, input logic t0, input logic t1,
                         input logic lru, input logic resp);
        mem_read      = pmr;
        pipe_mem_read = pmr;
        hit           = h;
        tag0_hit      = t0;
        tag1_hit      = t1;
        lru_out       = lru;
        pmem_resp     = resp;
    endtask

    // Drive one cycle's inputs after the falling edge and settle before checking.
    task automatic cyc(input logic pmr, input logic h, input logic t0, input logic t1,
                       input logic lru, input logic resp);
        @(negedge clk);
        drive(pmr, h, t0, t1, lru, resp);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,   "tbl_bubble"};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_MDET,  "tbl_miss_w1_detect"};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_MWAIT, "tbl_miss_wait"};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_FILL1, "tbl_fill_way1"};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_REF,   "tbl_refetch"};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BUB,   "tbl_stale"};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_HIT,   "tbl_hit_w1"};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, E_HIT,   "tbl_hit_w0"};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_BUB,   "tbl_resp_ignored"};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MDET,  "tbl_miss_w0_detect"};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_FILL0, "tbl_fill_way0_fast"};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_REF,   "tbl_refetch2"};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB,   "tbl_stale2"};

        // Reset held for three cycles
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 32'(E_ZERO));
        chk("reset_hits", hit_count, 32'd0);
        chk("reset_miss", miss_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_run", outs(), 32'(E_BUB));

        // Cold miss on 0x40, victim way0, response 5 cycles into MISS
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cold_detect", outs(), 32'(E_MDET));
        exp_miss++;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i == 4) ? 1'b1 : 1'b0);
            if (pmem_read) cnt++;
            if (i == 4) chk("cold_fill", outs(), 32'(E_FILL0));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (pmem_read) cnt++;
        chk("cold_pmem_cycles", 32'(cnt), 32'd5);
        chk("cold_refetch", outs(), 32'(E_REF));
        chk("cold_miss_count", miss_count, 32'(exp_miss));
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cold_stale", outs(), 32'(E_BUB));

        // Back-to-back hits on 0x40, 0x44, 0x48
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("burst_hit%0d", i), outs(), 32'(E_HIT));
            exp_hits++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("burst_hit_count", hit_count, 32'd3);

        // Same-set follow-on: miss to 0x100, then 0x100 again
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("follow_detect", outs(), 32'(E_MDET));
        exp_miss++;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("follow_fill", outs(), 32'(E_FILL1));
        cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (mem_resp) cnt++;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if (mem_resp) cnt++;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if (mem_resp) cnt++;
        chk("follow_hit", outs(), 32'(E_HIT));
        exp_hits++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (mem_resp) cnt++;
        chk("follow_resp_count", 32'(cnt), 32'd1);

        // Cycle-by-cycle vector table
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].pmr, tbl[i].h, tbl[i].t0, tbl[i].t1, tbl[i].lru, tbl[i].resp);
            chk(tbl[i].name, outs(), 32'(tbl[i].exp));
        end
        exp_hits += 2;
        exp_miss += 2;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tbl_hit_count", hit_count, 32'(exp_hits));
        chk("tbl_miss_count", miss_count, 32'(exp_miss));

        // Hit counter saturation
        @(negedge clk);
        force dut.hit_count_r = {CNT_W{1'b1}};
        #1;
        release dut.hit_count_r;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_hit_count", hit_count, {CNT_W{1'b1}});
        chk("sat_miss_untouched", miss_count, 32'(exp_miss));

        // Reset during MISS drops pmem_read at once with no array write
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmiss_pre", outs(), 32'(E_MWAIT));
        pmem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rstmiss_outs", outs(), 32'(E_ZERO));
        chk("rstmiss_hits", hit_count, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rstmiss_run", outs(), 32'(E_BUB));
        chk("rstmiss_miss", miss_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
